// File: rtl/dest_hazard_unit_pkg.sv
// Shared types and constants for the destination-tracking hazard unit:
// forwarding select encoding and the per-stage shadow record.
package dest_hazard_unit_pkg;

    localparam int REG_BITS = 5;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic [REG_BITS-1:0] dest;
        logic                regwrite;
        logic                memread;
    } stage_t;

endpackage

// File: rtl/dest_hazard_unit_if.sv
// Signal bundle between the pipeline latches and the hazard unit.
// master = pipeline side (drives EX/ID fields), slave = hazard unit.
interface dest_hazard_unit_if #(
    parameter int REG_BITS = dest_hazard_unit_pkg::REG_BITS
);
    logic [REG_BITS-1:0] ex_dest;
    logic                ex_regwrite;
    logic                ex_memread;
    logic [REG_BITS-1:0] id_rs;
    logic [REG_BITS-1:0] id_rt;
    logic [REG_BITS-1:0] ex_rs;
    logic [REG_BITS-1:0] ex_rt;
    logic [1:0]          fwd_a;
    logic [1:0]          fwd_b;
    logic                stall;
    logic [REG_BITS-1:0] mem_dest;
    logic [REG_BITS-1:0] wb_dest;
    logic                mem_regwrite;
    logic                wb_regwrite;

    modport master (
        output ex_dest, ex_regwrite, ex_memread, id_rs, id_rt, ex_rs, ex_rt,
        input  fwd_a, fwd_b, stall, mem_dest, wb_dest, mem_regwrite, wb_regwrite
    );

    modport slave (
        input  ex_dest, ex_regwrite, ex_memread, id_rs, id_rt, ex_rs, ex_rt,
        output fwd_a, fwd_b, stall, mem_dest, wb_dest, mem_regwrite, wb_regwrite
    );
endinterface

// File: rtl/dest_hazard_unit_dest_stage_reg.sv
// One shadow pipeline stage: registers {dest, regwrite, memread}.
// kill turns the captured instruction into a bubble (no write, no load).
module dest_stage_reg
    import dest_hazard_unit_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   kill,
    input  stage_t d,
    output stage_t q
);

    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples its neighbour's pre-edge value, giving true shift behaviour.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else begin
            q.dest     <= d.dest;
            q.regwrite <= d.regwrite & ~kill;
            q.memread  <= d.memread & ~kill;
        end
    end

endmodule

// File: rtl/dest_hazard_unit.sv
// Tracks EX destinations through MEM/WB shadow stages and derives ALU
// forwarding selects plus a one-cycle load-use stall.
module dest_hazard_unit
    import dest_hazard_unit_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    dest_hazard_unit_if.slave hz
);

    logic     bubble_q;
    logic     stall_c;
    fwd_sel_e fwd_a_c;
    fwd_sel_e fwd_b_c;
    stage_t   ex_s;
    stage_t   mem_s;
    stage_t   wb_s;

    assign ex_s = '{dest: hz.ex_dest, regwrite: hz.ex_regwrite, memread: hz.ex_memread};

    // The cycle after a stall, the ID/EX contents are a bubble whatever the
    // latch shows, so the EX->MEM capture is killed.
    dest_stage_reg u_ex_mem (
        .clk  (clk),
        .rst  (rst),
        .kill (bubble_q),
        .d    (ex_s),
        .q    (mem_s)
    );

    dest_stage_reg u_mem_wb (
        .clk  (clk),
        .rst  (rst),
        .kill (1'b0),
        .d    (mem_s),
        .q    (wb_s)
    );

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        fwd_a_c = FWD_RF;
        fwd_b_c = FWD_RF;
        stall_c = 1'b0;

        if (mem_s.regwrite && mem_s.dest != '0 && mem_s.dest == hz.ex_rs)
            fwd_a_c = FWD_MEM;
        else if (wb_s.regwrite && wb_s.dest != '0 && wb_s.dest == hz.ex_rs)
            fwd_a_c = FWD_WB;

        if (mem_s.regwrite && mem_s.dest != '0 && mem_s.dest == hz.ex_rt)
            fwd_b_c = FWD_MEM;
        else if (wb_s.regwrite && wb_s.dest != '0 && wb_s.dest == hz.ex_rt)
            fwd_b_c = FWD_WB;

        if (hz.ex_memread && !bubble_q && hz.ex_dest != '0 &&
            (hz.ex_dest == hz.id_rs || hz.ex_dest == hz.id_rt))
            stall_c = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) bubble_q <= 1'b0;
        else     bubble_q <= stall_c;
    end

    assign hz.fwd_a        = fwd_a_c;
    assign hz.fwd_b        = fwd_b_c;
    assign hz.stall        = stall_c;
    assign hz.mem_dest     = mem_s.dest;
    assign hz.wb_dest      = wb_s.dest;
    assign hz.mem_regwrite = mem_s.regwrite;
    assign hz.wb_regwrite  = wb_s.regwrite;

endmodule

// File: tb/tb_dest_hazard_unit.sv
// Directed vector table for the documented corner cases, then randomized
// traffic against an in-flight-list reference model.
module tb_dest_hazard_unit;

    typedef struct {
        bit       rst;
        bit [4:0] dest;
        bit       rw;
        bit       mr;
        bit [4:0] id_rs;
        bit [4:0] id_rt;
        bit [4:0] ex_rs;
        bit [4:0] ex_rt;
        bit       chk;
        bit [1:0] e_fa;
        bit [1:0] e_fb;
        bit       e_st;
        bit [4:0] e_md;
        bit [4:0] e_wd;
        bit       e_mrw;
        bit       e_wrw;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp  = 0;
    int   n_fail = 0;

    // Reference model: list of instructions in flight, index 0 = MEM, 1 = WB.
    bit [4:0] m_dest[2];
    bit       m_rw[2];
    bit       m_bub;

    dest_hazard_unit_if hz ();

    dest_hazard_unit dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    always #5 clk = ~clk;

    task automatic check(string name, logic [7:0] act, logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(bit r, int d, bit rw, bit mr, int irs, int irt,
                                int ers, int ert, bit c, int fa, int fb, bit st,
                                int md, int wd, bit mrw, bit wrw);
        vec_t v;
        v.rst = r;   v.dest = 5'(d); v.rw = rw; v.mr = mr;
        v.id_rs = 5'(irs); v.id_rt = 5'(irt); v.ex_rs = 5'(ers); v.ex_rt = 5'(ert);
        v.chk = c;   v.e_fa = 2'(fa); v.e_fb = 2'(fb); v.e_st = st;
        v.e_md = 5'(md); v.e_wd = 5'(wd); v.e_mrw = mrw; v.e_wrw = wrw;
        return v;
    endfunction

    function automatic bit [1:0] model_fwd(bit [4:0] src);
        for (int i = 0; i < 2; i++)
            if (m_rw[i] && m_dest[i] != 0 && m_dest[i] == src)
                return (i == 0) ? 2'b10 : 2'b01;
        return 2'b00;
    endfunction

    function automatic bit model_stall();
        return hz.ex_memread && !m_bub && hz.ex_dest != 0 &&
               (hz.ex_dest == hz.id_rs || hz.ex_dest == hz.id_rt);
    endfunction

    task automatic drive(vec_t v);
        rst            = v.rst;
        hz.ex_dest     = v.dest;
        hz.ex_regwrite = v.rw;
        hz.ex_memread  = v.mr;
        hz.id_rs       = v.id_rs;
        hz.id_rt       = v.id_rt;
        hz.ex_rs       = v.ex_rs;
        hz.ex_rt       = v.ex_rt;
    endtask

    // Advance the model by one edge using the inputs presented this cycle.
    task automatic clock_edge();
        bit s;
        s = model_stall();
        if (rst) begin
            m_dest = '{default: 5'd0};
            m_rw   = '{default: 1'b0};
            m_bub  = 1'b0;
        end else begin
            m_dest[1] = m_dest[0];
            m_rw[1]   = m_rw[0];
            m_dest[0] = hz.ex_dest;
            m_rw[0]   = hz.ex_regwrite && !m_bub;
            m_bub     = s;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(string tag, bit [1:0] fa, bit [1:0] fb, bit st,
                                 bit [4:0] md, bit [4:0] wd, bit mrw, bit wrw);
        check({tag, " fwd_a"},        8'(hz.fwd_a),        8'(fa));
        check({tag, " fwd_b"},        8'(hz.fwd_b),        8'(fb));
        check({tag, " stall"},        8'(hz.stall),        8'(st));
        check({tag, " mem_dest"},     8'(hz.mem_dest),     8'(md));
        check({tag, " wb_dest"},      8'(hz.wb_dest),      8'(wd));
        check({tag, " mem_regwrite"}, 8'(hz.mem_regwrite), 8'(mrw));
        check({tag, " wb_regwrite"},  8'(hz.wb_regwrite),  8'(wrw));
    endtask

    initial begin
        vec_t tv[$];
        vec_t v;

        //            rst dst rw mr irs irt ers ert chk fa fb st md wd mrw wrw
        tv.push_back(mk(1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); // reset 1
        tv.push_back(mk(1, 9, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0)); // reset 2
        tv.push_back(mk(0, 9, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 9, 0, 1, 0)); // 9 in MEM
        tv.push_back(mk(0, 8, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 9, 0, 1));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 8, 8, 1, 2, 2, 0, 8, 0, 1, 0)); // EX/MEM fwd
        tv.push_back(mk(0, 8, 1, 0, 0, 0, 8, 8, 1, 1, 1, 0, 0, 8, 0, 1)); // WB fwd
        tv.push_back(mk(0, 8, 1, 0, 0, 0, 8, 5, 1, 2, 0, 0, 8, 0, 1, 0));
        tv.push_back(mk(0, 3, 1, 0, 0, 0, 8, 8, 1, 2, 2, 0, 8, 8, 1, 1)); // MEM over WB
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 8, 3, 1, 1, 2, 0, 3, 8, 1, 1));
        tv.push_back(mk(0, 4, 1, 1, 7, 4, 0, 0, 1, 0, 0, 1, 0, 3, 0, 1)); // load-use
        tv.push_back(mk(0, 4, 1, 1, 7, 4, 0, 0, 1, 0, 0, 0, 4, 0, 1, 0)); // masked
        tv.push_back(mk(0, 9, 1, 0, 0, 0, 0, 4, 1, 0, 1, 0, 4, 4, 0, 1)); // bubble, WB fwd
        tv.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 9, 4, 1, 0)); // reg 0
        tv.push_back(mk(0, 0, 1, 1, 0, 0, 0, 9, 1, 0, 1, 0, 0, 9, 1, 1));
        tv.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1));
        tv.push_back(mk(1, 6, 1, 1, 6, 0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 1)); // reset mid-stall
        tv.push_back(mk(0, 6, 1, 1, 6, 0, 6, 0, 1, 0, 0, 1, 0, 0, 0, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 6, 0, 1, 2, 0, 0, 6, 0, 1, 0));

        m_dest = '{default: 5'd0};
        m_rw   = '{default: 1'b0};
        m_bub  = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < tv.size(); i++) begin
            v = tv[i];
            drive(v);
            #1;
            if (v.chk)
                check_outputs($sformatf("row%0d", i), v.e_fa, v.e_fb, v.e_st,
                              v.e_md, v.e_wd, v.e_mrw, v.e_wrw);
            clock_edge();
        end

        for (int n = 0; n < 500; n++) begin
            v.rst   = ($urandom_range(0, 31) == 0);
            v.dest  = 5'($urandom_range(0, 7));
            v.rw    = 1'($urandom);
            v.mr    = ($urandom_range(0, 2) == 0);
            v.id_rs = 5'($urandom_range(0, 7));
            v.id_rt = 5'($urandom_range(0, 7));
            v.ex_rs = 5'($urandom_range(0, 7));
            v.ex_rt = 5'($urandom_range(0, 7));
            drive(v);
            #1;
            check_outputs($sformatf("rnd%0d", n), model_fwd(hz.ex_rs), model_fwd(hz.ex_rt),
                          model_stall(), m_dest[0], m_dest[1], m_rw[0], m_rw[1]);
            clock_edge();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
